mfp_reg_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one write port of a bank of
//  mfp_register_r-style registers among NUM_REQ requesters (bus bridge,

---
 rtl/mfp_reg_wr_arbiter.sv | 111 +++++++++++
 tb/tb_mfp_reg_wr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mfp_reg_wr_arbiter.sv
// Round-robin write arbiter that shares one register-bank write port among NUM_REQ requesters.
// Grants strobe wr_en/ack/wr_sel for one cycle; lock lets the current owner keep the port.
module mfp_reg_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int WIDTH   = 32,
  parameter int AW      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*AW-1:0]    addr,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [WIDTH-1:0]         wr_data,
  output logic [2**AW-1:0]         wr_sel,
  output logic [IDW-1:0]           owner,
  output logic                     busy
);

  // state | meaning
  // IDLE  | arbitrate (or re-grant a locked owner), capture winner's addr/data
  // WRITE | one-cycle strobe of wr_en/ack/wr_sel, sample lock of the owner
  typedef enum logic {IDLE, WRITE} state_t;

  state_t                 state, state_nxt;
  logic                   locked, locked_nxt;
  logic [IDW-1:0]         owner_nxt;
  logic [AW-1:0]          wr_addr_nxt;
  logic [WIDTH-1:0]       wr_data_nxt;
  logic [NUM_REQ-1:0]     ack_nxt;
  logic [2**AW-1:0]       wr_sel_nxt;
  logic                   wr_en_nxt, busy_nxt;
  logic                   found;
  logic [IDW-1:0]         win, cand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      locked  <= 1'b0;
      owner   <= IDW'(NUM_REQ - 1);
      wr_addr <= '0;
      wr_data <= '0;
      ack     <= '0;
      wr_sel  <= '0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      locked  <= locked_nxt;
      owner   <= owner_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      ack     <= ack_nxt;
      wr_sel  <= wr_sel_nxt;
      wr_en   <= wr_en_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    locked_nxt  = locked;
    owner_nxt   = owner;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    ack_nxt     = '0;
    wr_sel_nxt  = '0;
    wr_en_nxt   = 1'b0;
    busy_nxt    = 1'b0;
    found       = 1'b0;
    win         = owner;
    cand        = owner;
    case (state)
      IDLE: begin
        if (locked && req[owner]) begin
          found = 1'b1;
        end else begin
          locked_nxt = 1'b0;
          // search starts just past the last owner so every requester rotates
          for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(owner) + k) % NUM_REQ);
            if (!found && req[cand]) begin
              found = 1'b1;
              win   = cand;
            end
          end
        end
        if (found) begin
          state_nxt           = WRITE;
          owner_nxt           = win;
          wr_addr_nxt         = addr[int'(win)*AW +: AW];
          wr_data_nxt         = data[int'(win)*WIDTH +: WIDTH];
          ack_nxt[win]        = 1'b1;
          wr_sel_nxt[wr_addr_nxt] = 1'b1;
          wr_en_nxt           = 1'b1;
          busy_nxt            = 1'b1;
        end
      end
      WRITE: begin
        locked_nxt = lock[owner];
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mfp_reg_wr_arbiter.sv
// Directed bench for mfp_reg_wr_arbiter: reset, single write, rotation, lock burst, wrap, withdraw.
module tb_mfp_reg_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int WIDTH   = 32;
  localparam int AW      = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ-1:0]       lock = '0;
  logic [NUM_REQ*AW-1:0]    addr = '0;
  logic [NUM_REQ*WIDTH-1:0] data = '0;
  logic [NUM_REQ-1:0]       ack;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [2**AW-1:0]         wr_sel;
  logic [IDW-1:0]           owner;
  logic                     busy;

  int n_chk  = 0;
  int n_pass = 0;

  mfp_reg_wr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .data(data),
    .ack(ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_sel(wr_sel), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one active edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    addr[i*AW +: AW]       = a;
    data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // expect a write strobe from requester r at address a
  task automatic chk_grant(input string tag, input int r, input logic [AW-1:0] a);
    logic [NUM_REQ-1:0] exp_ack;
    logic [2**AW-1:0]   exp_sel;
    exp_ack = '0;
    exp_ack[r] = 1'b1;
    exp_sel = '0;
    exp_sel[a] = 1'b1;
    chk({tag, ".ack"},   64'(ack),    64'(exp_ack));
    chk({tag, ".wr_en"}, 64'(wr_en),  64'd1);
    chk({tag, ".sel"},   64'(wr_sel), 64'(exp_sel));
    chk({tag, ".owner"}, 64'(owner),  64'(r));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".wr_en"}, 64'(wr_en),  64'd0);
    chk({tag, ".ack"},   64'(ack),    64'd0);
    chk({tag, ".sel"},   64'(wr_sel), 64'd0);
    chk({tag, ".busy"},  64'(busy),   64'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) set_src(i, AW'(i), 32'h1000 + i);

    // reset values
    tick();
    tick();
    chk_idle("rst");
    chk("rst.owner",   64'(owner),   64'd3);
    chk("rst.wr_addr", 64'(wr_addr), 64'd0);
    chk("rst.wr_data", 64'(wr_data), 64'd0);
    rst = 1'b1;

    // single write from requester 0
    set_src(0, 3'd3, 32'hDEADBEEF);
    req = 4'b0001;
    tick();
    chk_grant("single", 0, 3'd3);
    chk("single.data", 64'(wr_data), 64'hDEADBEEF);
    chk("single.addr", 64'(wr_addr), 64'd3);
    chk("single.busy", 64'(busy),    64'd1);
    req = '0;
    tick();
    chk_idle("single.after");

    // reset asserted in the middle of a write
    set_src(1, 3'd5, 32'h0000_5555);
    req = 4'b0010;
    tick();
    chk_grant("midw.pre", 1, 3'd5);
    #2 rst = 1'b0;
    #1;
    chk_idle("midw.rst");
    chk("midw.owner", 64'(owner), 64'd3);
    req = '0;
    tick();
    rst = 1'b1;
    set_src(2, 3'd2, 32'h0000_2222);
    req = 4'b0100;
    tick();
    chk_grant("midw.req2", 2, 3'd2);
    chk("midw.data", 64'(wr_data), 64'h2222);
    req = '0;
    tick();

    // round robin with all requesting, starting from reset owner 3
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_src(i, AW'(i + 4), 32'hA000 + i);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk_grant($sformatf("rr%0d", g), g % NUM_REQ, AW'((g % NUM_REQ) + 4));
      chk($sformatf("rr%0d.data", g), 64'(wr_data), 64'(32'hA000 + (g % NUM_REQ)));
      tick();
      chk($sformatf("rr%0d.gap", g), 64'(wr_en), 64'd0);
    end
    req = '0;
    tick();

    // lock burst: owner 0, so requester 1 wins first and keeps the port
    req  = 4'b0011;
    lock = 4'b0010;
    tick();
    chk_grant("lock1", 1, 3'd5);
    tick();
    chk("lock1.gap", 64'(wr_en), 64'd0);
    tick();
    chk_grant("lock2", 1, 3'd5);
    tick();
    lock = 4'b0000;
    tick();
    chk_grant("lock3", 1, 3'd5);
    tick();
    tick();
    chk_grant("lock.rel", 0, 3'd4);
    req = '0;
    tick();

    // wrap: move ownership to 3, then 0 must win before 3
    req = 4'b1000;
    tick();
    chk_grant("wrap.set", 3, 3'd7);
    req = '0;
    tick();
    req = 4'b1001;
    tick();
    chk_grant("wrap.0", 0, 3'd4);
    tick();
    tick();
    chk_grant("wrap.3", 3, 3'd7);
    req = '0;
    tick();

    // withdraw: requester 2 pulses only during another's write cycle
    set_src(0, 3'd1, 32'h0000_0011);
    set_src(2, 3'd6, 32'h0000_0066);
    req = 4'b0001;
    tick();
    chk_grant("wd.w0", 0, 3'd1);
    req = 4'b0100;
    tick();
    req = '0;
    chk_idle("wd.idle");
    tick();
    chk_idle("wd.none1");
    tick();
    chk_idle("wd.none2");
    chk("wd.owner", 64'(owner), 64'd0);

    // lock held but req dropped: lock released, normal arbitration resumes
    req  = 4'b0001;
    lock = 4'b0001;
    tick();
    chk_grant("lnr.w0", 0, 3'd1);
    req = 4'b0100;
    tick();
    chk("lnr.gap", 64'(wr_en), 64'd0);
    tick();
    chk_grant("lnr.w2", 2, 3'd6);
    req  = '0;
    lock = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end
endmodule
